mem_arbiter: RTL and testbench

- Arbitrates the single unified RAM port between the instruction fetch path (i-side) and the load/store path (d-side) of the pipelined MIPS core.
- Sequences each access with a small FSM and hands completion back to the pipeline as per-side wait signals.
- The hazard unit sees d-side wait as a pipeline stall source.
- Includes a timeout watchdog and error reporting.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the unified RAM port between i-fetch and load/store, with a timeout watchdog.
// Define ARB_STARVE_GUARD_EN to bound how long d-side traffic can starve instruction fetch.
module mem_arbiter #(
    parameter int TIMEOUT = 255
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramREN,
    output logic        ramWEN,
    output logic        memerr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IGRANT = 2'd1;
    localparam logic [1:0] DGRANT = 2'd2;

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic          wr_q, wr_d;
    logic          memerr_q, memerr_d;

    logic d_req;
    logic pick_i;
    logic granted_req;
    logic i_done;
    logic d_done;

    assign d_req = dREN | dWEN;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    // Once d-side has won SMAX times in a row over a waiting fetch, fetch goes next.
    assign pick_i = iREN & (~d_req | (starve_q == SMAX));

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!iREN || pick_i) begin
                starve_d = '0;
            end else if (d_req) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign pick_i = iREN & ~d_req;
`endif

    assign granted_req = (state_q == IGRANT) ? iREN : d_req;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        memerr_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_i) begin
                    state_d = IGRANT;
                    addr_d  = iaddr;
                    store_d = '0;
                    wr_d    = 1'b0;
                end else if (d_req) begin
                    state_d = DGRANT;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end
            end
            IGRANT, DGRANT: begin
                // Withdrawal wins over everything: the requester no longer cares about the result.
                if (!granted_req || ramstate == RS_ACCESS) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ramstate == RS_ERROR || cnt_q == TMAX) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    memerr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            memerr_q <= memerr_d;
        end
    end

    // Completion is reported combinationally so the pipeline can advance in the ACCESS cycle.
    assign i_done = (state_q == IGRANT) && (ramstate == RS_ACCESS);
    assign d_done = (state_q == DGRANT) && (ramstate == RS_ACCESS);

    assign iwait    = iREN & ~i_done;
    assign dwait    = d_req & ~d_done;
    assign iload    = i_done ? ramload : 32'h0;
    assign dload    = d_done ? ramload : 32'h0;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign ramREN   = (state_q == IGRANT) | ((state_q == DGRANT) & ~wr_q);
    assign ramWEN   = (state_q == DGRANT) & wr_q;
    assign memerr   = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle plus literal spot checks.
// Honours ARB_STARVE_GUARD_EN to pick the expected grant order under mixed traffic.
module tb_mem_arbiter;

    localparam int TIMEOUT = 8;
`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_LIM = 2;
`endif

    localparam logic [1:0] RS_FREE   = 2'b00;
    localparam logic [1:0] RS_BUSY   = 2'b01;
    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fails  = 0;

    mem_arbiter #(
        .TIMEOUT(TIMEOUT)
`ifdef ARB_STARVE_GUARD_EN
        ,
        .STARVE_LIMIT(STARVE_LIM)
`endif
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic i_r, input logic [31:0] i_a, input logic d_r, input logic d_w,
                                  input logic [31:0] d_a, input logic [31:0] d_s,
                                  input logic [1:0] rs, input logic [31:0] rl);
        iREN = i_r; iaddr = i_a; dREN = d_r; dWEN = d_w;
        daddr = d_a; dstore = d_s; ramstate = rs; ramload = rl;
    endtask

    // Model: owner 0 = nobody, 1 = fetch, 2 = data; age = cycles spent in the current grant.
    int          owner = 0;
    int          age = 0;
    int          starve = 0;
    logic [31:0] lat_addr = 0, lat_store = 0;
    logic        lat_write = 0;
    logic        err_pend = 0;

    always @(negedge CLK) begin
        logic i_done, d_done, req, take_i, err_next;
        if (!nRST) begin
            owner = 0; age = 0; starve = 0;
            lat_addr = 0; lat_store = 0; lat_write = 0; err_pend = 0;
        end
        i_done = (owner == 1) && (ramstate == RS_ACCESS);
        d_done = (owner == 2) && (ramstate == RS_ACCESS);
        check_output("iwait",  {31'b0, iwait},  {31'b0, iREN & ~i_done});
        check_output("dwait",  {31'b0, dwait},  {31'b0, (dREN | dWEN) & ~d_done});
        check_output("iload",  iload, i_done ? ramload : 32'h0);
        check_output("dload",  dload, d_done ? ramload : 32'h0);
        check_output("ramREN", {31'b0, ramREN}, {31'b0, (owner == 1) || (owner == 2 && !lat_write)});
        check_output("ramWEN", {31'b0, ramWEN}, {31'b0, (owner == 2) && lat_write});
        check_output("memerr", {31'b0, memerr}, {31'b0, err_pend});
        if (owner != 0) check_output("ramaddr", ramaddr, lat_addr);
        if (owner == 2) check_output("ramstore", ramstore, lat_store);

        if (nRST) begin
            err_next = 1'b0;
            if (owner == 0) begin
`ifdef ARB_STARVE_GUARD_EN
                take_i = iREN && (!(dREN || dWEN) || starve == STARVE_LIM);
`else
                take_i = iREN && !(dREN || dWEN);
`endif
                age = 0;
                if (!iREN) starve = 0;
                if (take_i) begin
                    owner = 1; lat_addr = iaddr; lat_store = 0; lat_write = 0; starve = 0;
                end else if (dREN || dWEN) begin
                    owner = 2; lat_addr = daddr; lat_store = dstore; lat_write = dWEN;
                    if (iREN) starve++;
                end
            end else begin
                req = (owner == 1) ? iREN : (dREN || dWEN);
                if (!req || ramstate == RS_ACCESS) begin
                    owner = 0;
                end else if (ramstate == RS_ERROR || age == TIMEOUT) begin
                    owner = 0; err_next = 1'b1;
                end else begin
                    age++;
                end
            end
            err_pend = err_next;
        end
    end

    initial begin
        byte   grants[$];
        string exp_order;

        nRST = 1'b0;
        apply_stimulus(1, 32'h40, 1, 0, 32'h80, 0, RS_FREE, 0);
        @(negedge CLK);
        check_output("rst_iwait",   {31'b0, iwait},  32'd1);
        check_output("rst_dwait",   {31'b0, dwait},  32'd1);
        check_output("rst_ramREN",  {31'b0, ramREN}, 32'd0);
        check_output("rst_ramaddr", ramaddr, 32'h0);
        check_output("rst_memerr",  {31'b0, memerr}, 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, RS_FREE, 0);
        nRST = 1'b1;
        tick();

        // Single instruction read, ACCESS two cycles after the grant.
        apply_stimulus(1, 32'h40, 0, 0, 0, 0, RS_BUSY, 0);
        tick();
        @(negedge CLK);
        check_output("ird_ramREN",  {31'b0, ramREN}, 32'd1);
        check_output("ird_ramaddr", ramaddr, 32'h40);
        tick();
        tick();
        ramstate = RS_ACCESS; ramload = 32'h2108000A;
        @(negedge CLK);
        check_output("ird_iwait", {31'b0, iwait}, 32'd0);
        check_output("ird_iload", iload, 32'h2108000A);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, RS_FREE, 0);
        @(negedge CLK);
        check_output("ird_idle_ren", {31'b0, ramREN}, 32'd0);
        tick();

        // Simultaneous fetch and load: data first.
        apply_stimulus(1, 32'h44, 1, 0, 32'h80, 0, RS_BUSY, 0);
        tick();
        @(negedge CLK);
        check_output("sim_daddr", ramaddr, 32'h80);
        check_output("sim_iwait", {31'b0, iwait}, 32'd1);
        tick();
        ramstate = RS_ACCESS; ramload = 32'h00001234;
        @(negedge CLK);
        check_output("sim_dload", dload, 32'h00001234);
        check_output("sim_iwait2", {31'b0, iwait}, 32'd1);
        tick();
        dREN = 0; ramstate = RS_BUSY;
        tick();
        @(negedge CLK);
        check_output("sim_iaddr", ramaddr, 32'h44);
        tick();
        ramstate = RS_ACCESS; ramload = 32'h00005678;
        @(negedge CLK);
        check_output("sim_iload", iload, 32'h00005678);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, RS_FREE, 0);
        tick();

        // Both data enables high is a write.
        apply_stimulus(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, RS_BUSY, 0);
        tick();
        @(negedge CLK);
        check_output("wr_ramWEN",   {31'b0, ramWEN}, 32'd1);
        check_output("wr_ramREN",   {31'b0, ramREN}, 32'd0);
        check_output("wr_ramstore", ramstore, 32'hDEADBEEF);
        tick();
        ramstate = RS_ACCESS;
        @(negedge CLK);
        check_output("wr_dwait", {31'b0, dwait}, 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, RS_FREE, 0);
        tick();

        // Timeout with RAM held BUSY, then automatic re-grant.
        apply_stimulus(0, 0, 1, 0, 32'h200, 0, RS_BUSY, 0);
        tick();
        repeat (TIMEOUT) tick();
        @(negedge CLK);
        check_output("to_last_memerr", {31'b0, memerr}, 32'd0);
        check_output("to_last_ramREN", {31'b0, ramREN}, 32'd1);
        tick();
        @(negedge CLK);
        check_output("to_memerr", {31'b0, memerr}, 32'd1);
        check_output("to_ramREN", {31'b0, ramREN}, 32'd0);
        check_output("to_dwait",  {31'b0, dwait},  32'd1);
        tick();
        @(negedge CLK);
        check_output("to_regrant", {31'b0, ramREN}, 32'd1);
        check_output("to_pulse",   {31'b0, memerr}, 32'd0);
        tick();
        ramstate = RS_ACCESS;
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, RS_FREE, 0);
        tick();

        // RAM ERROR mid-grant.
        apply_stimulus(0, 0, 1, 0, 32'h300, 0, RS_BUSY, 0);
        tick();
        tick();
        ramstate = RS_ERROR;
        @(negedge CLK);
        check_output("err_dwait", {31'b0, dwait}, 32'd1);
        tick();
        dREN = 0; ramstate = RS_BUSY;
        @(negedge CLK);
        check_output("err_memerr", {31'b0, memerr}, 32'd1);
        check_output("err_ramREN", {31'b0, ramREN}, 32'd0);
        tick();
        ramstate = RS_FREE;
        tick();

        // Withdrawal after one BUSY cycle.
        apply_stimulus(0, 0, 1, 0, 32'h400, 0, RS_BUSY, 0);
        tick();
        tick();
        dREN = 0;
        tick();
        @(negedge CLK);
        check_output("wd_ramREN", {31'b0, ramREN}, 32'd0);
        check_output("wd_memerr", {31'b0, memerr}, 32'd0);
        tick();
        @(negedge CLK);
        check_output("wd_memerr2", {31'b0, memerr}, 32'd0);
        tick();

        // Continuous mixed traffic; every grant completes immediately.
        apply_stimulus(1, 32'h600, 1, 0, 32'h500, 0, RS_ACCESS, 32'h0BADF00D);
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (ramREN) grants.push_back((ramaddr == 32'h600) ? 8'h49 : 8'h44);
            tick();
        end
`ifdef ARB_STARVE_GUARD_EN
        exp_order = "DDIDDI";
`else
        exp_order = "DDDDDD";
`endif
        check_output("grant_count", grants.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check_output($sformatf("grant_%0d", k), (k < grants.size()) ? {24'b0, grants[k]} : 32'h0,
                         {24'b0, exp_order[k]});
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, RS_FREE, 0);
        tick();

        // Asynchronous reset in the middle of a grant.
        apply_stimulus(0, 0, 1, 0, 32'h700, 0, RS_BUSY, 0);
        tick();
        #2;
        nRST = 1'b0;
        #1;
        check_output("mrst_ramREN", {31'b0, ramREN}, 32'd0);
        check_output("mrst_dwait",  {31'b0, dwait},  32'd1);
        check_output("mrst_dload",  dload, 32'h0);
        tick();
        dREN = 0;
        nRST = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
